// File: rtl/mmu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmu_seq_ctrl
// Purpose  : Load / compute / drain sequencer for an N x N systolic matrix unit
// Revision : 1.0
// ============================================================================
module mmu_seq_ctrl #(
    parameter int N    = 2,
    parameter int ACCW = 16,
    parameter int AW   = $clog2(2*N*N),
    parameter int KW   = (N > 2) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              transpose,
    input  logic              continuous,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              mem_wr_en,
    output logic [AW-1:0]     mem_addr,
    output logic              clear,
    output logic              data_valid,
    output logic              transpose_out,
    output logic [N-1:0]      a_en,
    output logic [N-1:0]      b_en,
    output logic [N*KW-1:0]   a_sel,
    output logic [N*KW-1:0]   b_sel,
    input  logic [N*N*ACCW-1:0] c_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy
);
    localparam int c_BPR = ACCW / 8;
    localparam int c_NB  = N * N * c_BPR;
    localparam int c_IW  = $clog2(c_NB);
    localparam int c_TW  = $clog2(3 * N);
    localparam logic [AW-1:0]   c_LAST_ADDR = AW'(2 * N * N - 1);
    localparam logic [c_TW-1:0] c_LAST_T    = c_TW'(3 * N - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(c_NB - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_TW-1:0]       r_t, w_t_nxt;
    logic [AW-1:0]         r_addr;
    logic [c_IW-1:0]       r_idx;
    logic [N*N*ACCW-1:0]   r_buf;
    logic                  r_load_ready, r_clear, r_data_valid, r_out_valid, r_busy, r_transpose;
    logic [N-1:0]          r_lane_en, w_lane_en;
    logic [N*KW-1:0]       r_lane_sel, w_lane_sel;
    logic [7:0]            w_bytes [c_NB];
    logic                  w_load_hs, w_load_done, w_t_done, w_out_hs, w_drain_done;

    assign w_load_hs    = load_valid && r_load_ready;
    assign w_load_done  = w_load_hs && (r_addr == c_LAST_ADDR);
    assign w_t_done     = (r_state == S_COMPUTE) && (r_t == c_LAST_T);
    assign w_out_hs     = r_out_valid && out_ready;
    assign w_drain_done = w_out_hs && (r_idx == c_LAST_IDX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start)        w_state_nxt = S_LOAD;
            S_LOAD:    if (w_load_done)  w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_t_done)     w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_drain_done) w_state_nxt = continuous ? S_LOAD : S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    assign w_t_nxt = (r_state == S_COMPUTE && !w_t_done) ? r_t + 1'b1 : '0;

    // Lane outputs are registered from the next-cycle value of t so they line up with it.
    always_comb begin
        w_lane_en  = '0;
        w_lane_sel = '0;
        if (w_state_nxt == S_COMPUTE) begin
            for (int i = 0; i < N; i++) begin
                if (w_t_nxt >= c_TW'(i + 1) && w_t_nxt <= c_TW'(N + i)) begin
                    w_lane_en[i]            = 1'b1;
                    w_lane_sel[i*KW +: KW]  = KW'(w_t_nxt - c_TW'(i + 1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_t          <= '0;
            r_addr       <= '0;
            r_idx        <= '0;
            r_buf        <= '0;
            r_load_ready <= 1'b0;
            r_clear      <= 1'b0;
            r_data_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_transpose  <= 1'b0;
            r_lane_en    <= '0;
            r_lane_sel   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_t          <= w_t_nxt;
            r_load_ready <= (w_state_nxt == S_LOAD);
            r_data_valid <= (w_state_nxt == S_COMPUTE);
            r_out_valid  <= (w_state_nxt == S_DRAIN);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_clear      <= (w_state_nxt == S_COMPUTE) && (w_t_nxt == '0);
            r_lane_en    <= w_lane_en;
            r_lane_sel   <= w_lane_sel;
            if (w_load_done)
                r_addr <= '0;
            else if (w_load_hs)
                r_addr <= r_addr + 1'b1;
            if (w_drain_done)
                r_idx <= '0;
            else if (w_out_hs)
                r_idx <= r_idx + 1'b1;
            if (w_t_done)
                r_buf <= c_flat;
            if (w_state_nxt == S_LOAD && r_state != S_LOAD)
                r_transpose <= transpose;
        end
    end

    // Byte n of the stream: result n/BPR, most significant byte first.
    for (genvar n = 0; n < c_NB; n++) begin : g_byte
        localparam int c_RES = n / c_BPR;
        localparam int c_SUB = c_BPR - 1 - (n % c_BPR);
        assign w_bytes[n] = r_buf[c_RES*ACCW + c_SUB*8 +: 8];
    end

    assign load_ready    = r_load_ready;
    assign mem_wr_en     = w_load_hs;
    assign mem_addr      = r_addr;
    assign clear         = r_clear;
    assign data_valid    = r_data_valid;
    assign transpose_out = r_transpose;
    // Rows and columns share the same skew schedule.
    assign a_en          = r_lane_en;
    assign b_en          = r_lane_en;
    assign a_sel         = r_lane_sel;
    assign b_sel         = r_lane_sel;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_valid ? w_bytes[r_idx] : 8'd0;
    assign out_last      = r_out_valid && (r_idx == c_LAST_IDX);
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mmu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_seq_ctrl
// Purpose  : Self-checking bench for mmu_seq_ctrl (N=2 jobs, N=3 skew table)
// Revision : 1.0
// ============================================================================
module tb_mmu_seq_ctrl;
    logic clk, rst_n;

    // N=2, ACCW=16 instance
    logic start, transpose, continuous, load_valid, out_ready;
    logic load_ready, mem_wr_en, clear, data_valid, transpose_out, out_valid, out_last, busy;
    logic [2:0]  mem_addr;
    logic [1:0]  a_en, b_en, a_sel, b_sel;
    logic [63:0] c_flat;
    logic [7:0]  out_data;

    // N=3, ACCW=16 instance
    logic start3, load_valid3;
    logic load_ready3, mem_wr_en3, clear3, data_valid3, transpose_out3, out_valid3, out_last3, busy3;
    logic [4:0]   mem_addr3;
    logic [2:0]   a_en3, b_en3;
    logic [5:0]   a_sel3, b_sel3;
    logic [143:0] c_flat3;
    logic [7:0]   out_data3;

    mmu_seq_ctrl #(.N(2), .ACCW(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose), .continuous(continuous),
        .load_valid(load_valid), .load_ready(load_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .clear(clear), .data_valid(data_valid), .transpose_out(transpose_out),
        .a_en(a_en), .b_en(b_en), .a_sel(a_sel), .b_sel(b_sel), .c_flat(c_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    mmu_seq_ctrl #(.N(3), .ACCW(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .transpose(1'b1), .continuous(1'b0),
        .load_valid(load_valid3), .load_ready(load_ready3), .mem_wr_en(mem_wr_en3), .mem_addr(mem_addr3),
        .clear(clear3), .data_valid(data_valid3), .transpose_out(transpose_out3),
        .a_en(a_en3), .b_en(b_en3), .a_sel(a_sel3), .b_sel(b_sel3), .c_flat(c_flat3),
        .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3), .out_last(out_last3),
        .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [2:0] en;
        logic [5:0] sel;
        logic       clr;
    } skew_t;
    skew_t tbl[9];

    // Output monitor: compares every accepted byte against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got %0h expected none", out_data);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", {56'd0, out_data}, {56'd0, mon_e.d});
                check("out_last", {63'd0, out_last}, {63'd0, mon_e.l});
            end
        end
    end

    task automatic push_results(input logic [15:0] v0, v1, v2, v3);
        logic [15:0] v [4];
        exp_t e;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        c_flat = {v3, v2, v1, v0};
        for (int r = 0; r < 4; r++) begin
            e.d = v[r][15:8]; e.l = 1'b0;          sb.push_back(e);
            e.d = v[r][7:0];  e.l = (r == 3);      sb.push_back(e);
        end
    endtask

    task automatic job(input bit need_start, input bit gapped, input bit tr, input bit cont,
                       input bit next_tr, input logic [15:0] v0, v1, v2, v3, input bit stall);
        int acc, budget, clr_cnt, dv_cnt, stalls;
        transpose = tr;
        if (need_start) begin
            @(negedge clk); start = 1'b1; #1;
            check("idle_busy", {63'd0, busy}, 64'd0);
            @(negedge clk); start = 1'b0; #1;
            check("ready_rise", {63'd0, load_ready}, 64'd1);
        end
        check("addr_start", {61'd0, mem_addr}, 64'd0);
        acc = 0; budget = 0;
        while (acc < 8 && budget < 64) begin
            @(negedge clk);
            load_valid = gapped ? (budget % 2 == 0) : 1'b1;
            #1;
            if (mem_wr_en) begin
                check("wr_addr", {61'd0, mem_addr}, 64'(acc));
                acc++;
            end
            budget++;
        end
        check("load_count", 64'(acc), 64'd8);
        check("tr_out", {63'd0, transpose_out}, {63'd0, tr});
        push_results(v0, v1, v2, v3);
        clr_cnt = 0; dv_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            load_valid = (c == 2);
            start = (c == 3);
            #1;
            if (c == 0) check("clear_first", {63'd0, clear}, 64'd1);
            if (c == 2) check("wr_in_compute", {63'd0, mem_wr_en}, 64'd0);
            if (c == 3) check("addr_compute", {61'd0, mem_addr}, 64'd0);
            if (c == 5) check("ov_before", {63'd0, out_valid}, 64'd0);
            if (c == 6) check("ov_rise", {63'd0, out_valid}, 64'd1);
            clr_cnt += int'(clear);
            dv_cnt  += int'(data_valid);
        end
        check("clear_cycles", 64'(clr_cnt), 64'd1);
        check("dv_cycles", 64'(dv_cnt), 64'd6);
        continuous = cont;
        transpose = next_tr;
        stalls = 0; budget = 0;
        while (budget < 100) begin
            @(negedge clk);
            if (sb.size() == 0) break;
            out_ready = !(stall && out_data == 8'h03 && stalls < 3);
            if (!out_ready) stalls++;
            start = (budget == 3);
            if (budget == 2) c_flat = ~c_flat;
            #1;
            if (!out_ready) begin
                check("stall_data", {56'd0, out_data}, 64'h03);
                check("stall_last", {63'd0, out_last}, 64'd0);
            end
            budget++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
        if (stall) check("stall_count", 64'(stalls), 64'd3);
        if (cont) begin
            check("cont_ready", {63'd0, load_ready}, 64'd1);
            check("cont_busy", {63'd0, busy}, 64'd1);
            check("cont_tr", {63'd0, transpose_out}, {63'd0, next_tr});
        end else begin
            check("idle_busy_end", {63'd0, busy}, 64'd0);
            load_valid = 1'b1;
            #1;
            check("idle_wr", {63'd0, mem_wr_en}, 64'd0);
            @(negedge clk); load_valid = 1'b0; #1;
            check("idle_addr", {61'd0, mem_addr}, 64'd0);
            check("idle_ready", {63'd0, load_ready}, 64'd0);
        end
    endtask

    initial begin
        tbl[0] = '{3'b000, 6'b000000, 1'b1};
        tbl[1] = '{3'b001, 6'b000000, 1'b0};
        tbl[2] = '{3'b011, 6'b000001, 1'b0};
        tbl[3] = '{3'b111, 6'b000110, 1'b0};
        tbl[4] = '{3'b110, 6'b011000, 1'b0};
        tbl[5] = '{3'b100, 6'b100000, 1'b0};
        tbl[6] = '{3'b000, 6'b000000, 1'b0};
        tbl[7] = '{3'b000, 6'b000000, 1'b0};
        tbl[8] = '{3'b000, 6'b000000, 1'b0};

        rst_n = 1'b0; start = 1'b0; transpose = 1'b0; continuous = 1'b0;
        load_valid = 1'b0; out_ready = 1'b0; c_flat = '0;
        start3 = 1'b0; load_valid3 = 1'b0; c_flat3 = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, load_ready}, 64'd0);
        check("rst_outs", {39'd0, clear, data_valid, transpose_out, a_en, b_en, a_sel, b_sel,
                           out_valid, out_data, out_last, mem_addr, mem_wr_en}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Gapped load + backpressured drain, continuing straight into a second job.
        job(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0102, 16'h0304, 16'h0506, 16'hFFF8, 1'b1);
        job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 16'h00FF, 16'hAB01, 1'b0);

        // N=3 skew schedule
        begin
            int acc, budget;
            @(negedge clk); start3 = 1'b1;
            @(negedge clk); start3 = 1'b0;
            acc = 0; budget = 0;
            while (acc < 18 && budget < 60) begin
                @(negedge clk); load_valid3 = 1'b1; #1;
                if (mem_wr_en3) acc++;
                budget++;
            end
            check("load3_count", 64'(acc), 64'd18);
            for (int t = 0; t < 9; t++) begin
                @(negedge clk); load_valid3 = 1'b0; #1;
                check($sformatf("a_en3_t%0d", t), {61'd0, a_en3}, {61'd0, tbl[t].en});
                check($sformatf("a_sel3_t%0d", t), {58'd0, a_sel3}, {58'd0, tbl[t].sel});
                check($sformatf("b_en3_t%0d", t), {61'd0, b_en3}, {61'd0, tbl[t].en});
                check($sformatf("b_sel3_t%0d", t), {58'd0, b_sel3}, {58'd0, tbl[t].sel});
                check($sformatf("clear3_t%0d", t), {63'd0, clear3}, {63'd0, tbl[t].clr});
                check($sformatf("tr3_t%0d", t), {63'd0, transpose_out3}, 64'd1);
            end
        end

        // Asynchronous reset in the middle of LOAD
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; load_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_addr", {61'd0, mem_addr}, 64'd3);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_ready", {63'd0, load_ready}, 64'd0);
        check("arst_addr", {61'd0, mem_addr}, 64'd0);
        check("arst_wr", {63'd0, mem_wr_en}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("post_rst_ready", {63'd0, load_ready}, 64'd0);
            check("post_rst_wr", {63'd0, mem_wr_en}, 64'd0);
        end
        load_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/mmu_seq_ctrl.md
# mmu_seq_ctrl

Parametrised sequencer for an N×N systolic matrix unit. It accepts the operand stream from the host through a valid/ready handshake and addresses operand memory. It then drives skewed per-lane feed selects and the accumulator clear into the array, snapshots the N×N results, and serialises them to the host byte by byte with backpressure. It sits between the host byte interface, the operand memory and the systolic array, and supports an optional continuous (back-to-back job) mode.

## Interface
Parameters:
- N, 2: array dimension; legal range 2..8.
- ACCW, 16: result width per PE in bits; must be a multiple of 8.
- AW, $clog2(2*N*N): operand memory address width.
- KW, $clog2(N) (minimum 1): feed-select index width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a job; sampled only in IDLE.
- transpose  in  1  operand-B orientation; sampled on every entry to LOAD.
- continuous  in  1  sampled on the final DRAIN handshake; 1 returns to LOAD, 0 returns to IDLE.
- load_valid  in  1  host operand byte valid.
- load_ready  out  1  high only in LOAD.
- mem_wr_en  out  1  high on the cycle a load handshake occurs (load_valid && load_ready).
- mem_addr  out  AW  write address for the accepted byte.
- clear  out  1  one-cycle accumulator clear.
- data_valid  out  1  high throughout COMPUTE.
- transpose_out  out  1  registered transpose, held constant for the whole job.
- a_en, b_en  out  N  per-row and per-column lane enable.
- a_sel, b_sel  out  N*KW  per-lane element index k; lane i occupies bits [i*KW +: KW].
- c_flat  in  N*N*ACCW  array results, row-major; c(i,j) at bits [(i*N+j)*ACCW +: ACCW].
- out_valid  out  1  result byte valid.
- out_ready  in  1  host accepts the result byte.
- out_data  out  8  result byte.
- out_last  out  1  high with the final byte of a job.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, LOAD, COMPUTE and DRAIN.
- IDLE to LOAD on start. A start seen outside IDLE is ignored.
- LOAD:
  - Accepts exactly 2·N² bytes: weights W row-major at addresses 0..N²−1, then inputs X row-major at N²..2N²−1.
  - mem_addr holds the address of the next byte and starts at 0 on entry. It increments after each handshake.
  - Cycles without a handshake leave mem_addr unchanged.
  - The transition to COMPUTE follows the handshake at address 2N²−1. mem_addr returns to 0 on that transition.
- COMPUTE:
  - A cycle counter t runs 0..3N−1, for 3N cycles total.
  - clear=1 only at t=0.
  - Row lane i and column lane j are enabled when 1+i ≤ t ≤ N+i (respectively N+j); the lane index is k = t−1−i (respectively t−1−j).
  - a_sel and b_sel are 0 for disabled lanes.
  - At t=3N−1, c_flat is captured into an internal result buffer and the state moves to DRAIN.
- DRAIN:
  - Emits N²·(ACCW/8) bytes, results row-major, each result MSB byte first. Values are raw two's complement.
  - The byte index advances only on out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - Because the result buffer is a snapshot, changes on c_flat during DRAIN have no effect on the emitted bytes.
  - On the last handshake: continuous ? LOAD : IDLE.
- Reset (rst_n low):
  - State goes to IDLE immediately, independent of clk.
  - All counters and the result buffer are cleared to 0.
  - Every output reads 0: load_ready, mem_wr_en, mem_addr, clear, data_valid, transpose_out, a_en/b_en, a_sel/b_sel, out_valid, out_data, out_last, busy.
  - A reset mid-job discards the job with no partial output.

## Timing
- All outputs are registered except these two:
  - mem_wr_en = load_valid && load_ready (combinational).
  - out_data, out_last and out_valid are driven from the buffer index register.
- load_ready rises the cycle after start is sampled, and falls the cycle after the final handshake.
- clear rises the cycle after the final load handshake.
- out_valid first rises 3N+1 cycles after the final load handshake (3N COMPUTE cycles, then DRAIN entry).
- Maximum throughput is one operand byte per cycle in and one result byte per cycle out.
- Continuous mode: load_ready=1 on the cycle after the last out handshake; no start is needed. transpose_out updates on that same edge.

## Test plan
- Async reset: pull rst_n low mid-LOAD between clock edges → busy, load_ready and mem_addr read 0 before the next edge. After release, start is required again.
- Gapped load (N=2): drive 8 bytes with load_valid toggling every cycle → mem_wr_en pulses exactly 8 times with mem_addr 0..7. clear is high for exactly one cycle, the cycle after the 8th accept, and data_valid is high for 6 cycles.
- Skew (N=3): a_en[2] is high at t=3,4,5 with a_sel lane 2 = 0,1,2. a_en[0] is high at t=1..3. All lanes are 0 at t=0 and at t=7,8.
- Drain with backpressure (N=2, ACCW=16): c_flat = {0x0102, 0x0304, 0x0506, 0xFFF8} → out_data sequence 01 02 03 04 05 06 FF F8, with out_last only on F8. Holding out_ready low for 3 cycles on byte 03 keeps 03 stable. Changing c_flat during DRAIN leaves the output unchanged.
- Continuous mode: continuous=1 at the last handshake → next cycle LOAD, load_ready=1, busy stays 1. Repeat with continuous=0 → IDLE, busy=0, and a pulse on load_valid is ignored.
- Stray start: pulse start during COMPUTE and during DRAIN → no effect on t, mem_addr or the output byte sequence.
